// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Multiplexed 7-segment scan driver for the clock display. Each field is a
//   7-bit binary value (seconds, minutes, hours, ...). It is split into a
//   units digit (even digit index) and a tens digit (odd digit index). The
//   digits are time-multiplexed onto one shared set of segment lines.
//
//   A snapshot of every input is taken once per frame, so a whole frame is
//   always drawn from one coherent set of values. Each digit slot begins with
//   a short all-off window, which stops the previous digit's segments ghosting
//   onto the next digit. The module also provides per-field blink, a per-digit
//   decimal point, a dash mode, and a dash glyph for values >= 100.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   fields      N_DIGITS/2 packed 7-bit fields; field 0 at [6:0]
//   blink_mask  per-field blink enable
//   dp_mask     per-digit decimal point request
//   dash        show "-" on every digit
//   brightness  (DISP_DIM_EN only) 4-bit PWM duty; 15 = fully on
//   dig         digit selects, active low, at most one low at a time
//   seg         {dp,g,f,e,d,c,b,a}; inverted when SEG_ACTIVE_LOW=1
//   frame_tick  one-cycle pulse in the first cycle after a snapshot loads
//
// Build option
//   DISP_DIM_EN  adds the brightness input and a free-running PWM gate on
//                the digit select during the SHOW part of each slot.
module seg_scan_display #(
  parameter int N_DIGITS       = 6,
  parameter int CLK_HZ         = 50000000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLANK_CYC      = 16,
  parameter int BLINK_HZ       = 2,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7*N_DIGITS/2-1:0]   fields,
  input  logic [N_DIGITS/2-1:0]     blink_mask,
  input  logic [N_DIGITS-1:0]       dp_mask,
  input  logic                      dash,
`ifdef DISP_DIM_EN
  input  logic [3:0]                brightness,
`endif
  output logic [N_DIGITS-1:0]       dig,
  output logic [7:0]                seg,
  output logic                      frame_tick
);

  localparam int NF       = N_DIGITS / 2;
  localparam int FW       = 7 * NF;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW       = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END  = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [BW-1:0]    BLINK_LAST = BW'(HALF - 1);
  localparam logic [7:0]       SEG_INV    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [6:0]       GLYPH_DASH = 7'h40;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } slot_t;

  // Segment font for 0..9, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] font(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = GLYPH_DASH;
    endcase
    return g;
  endfunction

  // Glyph for one half of a field. A field that cannot be shown as two
  // decimal digits shows a dash on both of its digits.
  function automatic logic [6:0] glyph(input logic [6:0] v, input logic tens);
    logic [3:0] d;
    if (v >= 7'd100) begin
      return GLYPH_DASH;
    end
    d = tens ? 4'(v / 7'd10) : 4'(v % 7'd10);
    return font(d);
  endfunction

  // Scan position, slot state and blink timebase
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic [IDX_W-1:0] idx_q, idx_next;
  slot_t            slot_q, slot_next;
  logic [BW-1:0]    bcnt_q;
  logic             phase_q;
  logic             tick;
  logic             wrap;

  // Frame snapshot
  logic [FW-1:0]       snap_fields_q;
  logic [NF-1:0]       snap_blink_q;
  logic [N_DIGITS-1:0] snap_dp_q;
  logic                snap_dash_q;
  logic                frame_q;

`ifdef DISP_DIM_EN
  logic [3:0] pwm_q;
  logic [3:0] snap_bright_q;
`endif

  // Output registers
  logic [N_DIGITS-1:0] dig_p1, dig_next;
  logic [7:0]          seg_p1, seg_next;

  assign tick = (cnt_q == CNT_LAST);
  assign wrap = tick && (idx_q == IDX_LAST);

  // Slot FSM next state. BLANK covers the first BLANK_CYC counts of a slot,
  // so the state is derived from the count that the slot moves to next.
  always_comb begin
    cnt_next  = cnt_q + 1'b1;
    idx_next  = idx_q;
    slot_next = slot_q;
    if (tick) begin
      cnt_next = '0;
      idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    slot_next = (cnt_next < BLANK_END) ? BLANK : SHOW;
  end

  // ---- stage 0: scan counters, blink timebase, frame snapshot ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      slot_q        <= (BLANK_CYC > 0) ? BLANK : SHOW;
      bcnt_q        <= '0;
      phase_q       <= 1'b0;
      snap_fields_q <= '0;
      snap_blink_q  <= '0;
      snap_dp_q     <= '0;
      snap_dash_q   <= 1'b0;
      frame_q       <= 1'b0;
    end else begin
      cnt_q   <= cnt_next;
      idx_q   <= idx_next;
      slot_q  <= slot_next;
      frame_q <= wrap;
      if (bcnt_q == BLINK_LAST) begin
        bcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        bcnt_q <= bcnt_q + 1'b1;
      end
      if (wrap) begin
        snap_fields_q <= fields;
        snap_blink_q  <= blink_mask;
        snap_dp_q     <= dp_mask;
        snap_dash_q   <= dash;
      end
    end
  end

`ifdef DISP_DIM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q         <= '0;
      snap_bright_q <= '0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
      if (wrap) begin
        snap_bright_q <= brightness;
      end
    end
  end
`endif

  // Decode of the current slot. dig and seg are both computed here from the
  // same idx/slot, so they reach the pins on the same edge.
  always_comb begin
    logic [6:0] v;
    logic       fblink;
    logic       dpb;
    logic       lit;

    v        = '0;
    fblink   = 1'b0;
    dpb      = 1'b0;
    dig_next = '1;
    seg_next = 8'h00;

`ifdef DISP_DIM_EN
    lit = (pwm_q <= snap_bright_q);
`else
    lit = 1'b1;
`endif

    for (int f = 0; f < NF; f++) begin
      if (IDX_W'(f) == (idx_q >> 1)) begin
        v      = snap_fields_q[7*f +: 7];
        fblink = snap_blink_q[f];
      end
    end

    for (int d = 0; d < N_DIGITS; d++) begin
      if (IDX_W'(d) == idx_q) begin
        dpb = snap_dp_q[d];
        if (slot_q == SHOW && lit) begin
          dig_next[d] = 1'b0;
        end
      end
    end

    // Dash mode outranks blink, which outranks the normal glyph.
    if (snap_dash_q) begin
      seg_next = {1'b0, GLYPH_DASH};
    end else if (phase_q && fblink) begin
      seg_next = 8'h00;
    end else begin
      seg_next = {dpb, glyph(v, idx_q[0])};
    end
  end

  // ---- stage 1: registered pin drivers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_p1 <= '1;
      seg_p1 <= 8'h00;
    end else begin
      dig_p1 <= dig_next;
      seg_p1 <= seg_next;
    end
  end

  assign dig        = dig_p1;
  assign seg        = seg_p1 ^ SEG_INV;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [20:0] fields = '0;
  logic [2:0]  blink_mask = '0;
  logic [5:0]  dp_mask = '0;
  logic        dash = 1'b0;
  logic [5:0]  dig;
  logic [7:0]  seg;
  logic        frame_tick;
`ifdef DISP_DIM_EN
  logic [3:0]  brightness = 4'hF;
`endif

  int total = 0;
  int bad = 0;

  seg_scan_display #(
    .N_DIGITS(6), .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(2),
    .BLINK_HZ(10), .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fields(fields), .blink_mask(blink_mask),
    .dp_mask(dp_mask), .dash(dash),
`ifdef DISP_DIM_EN
    .brightness(brightness),
`endif
    .dig(dig), .seg(seg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 10-cycle slots, 2 blank cycles, 50-cycle blink phase
  typedef struct packed {
    logic [5:0] dig;
    logic [7:0] seg;
    logic       ft;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_pop;
  int          m_cnt, m_idx, m_bcnt;
  logic        m_phase;
  logic [20:0] m_f;
  logic [2:0]  m_bl;
  logic [5:0]  m_dp;
  logic        m_dash;

  function automatic logic [6:0] font(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      default: return 7'h6F;
    endcase
  endfunction

  function automatic logic [7:0] model_seg(input int k);
    logic [6:0] v;
    logic [6:0] g;
    logic [2:0] bl;
    logic [5:0] dps;
    int         di;
    bl  = m_bl >> (k / 2);
    dps = m_dp >> k;
    if (m_dash) return 8'h40;
    if (m_phase && bl[0]) return 8'h00;
    v = 7'(m_f >> (7 * (k / 2)));
    if (v >= 7'd100) begin
      g = 7'h40;
    end else begin
      di = (k % 2 == 1) ? int'(v) / 10 : int'(v) % 10;
      g  = font(di);
    end
    return {dps[0], g};
  endfunction

  function automatic exp_t mk_exp();
    exp_t e;
    e.dig = (m_cnt < 2) ? 6'h3F : ~(6'b1 << m_idx);
    e.seg = model_seg(m_idx);
    e.ft  = (m_cnt == 9 && m_idx == 5);
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= 0;
      m_idx   <= 0;
      m_bcnt  <= 0;
      m_phase <= 1'b0;
      m_f     <= '0;
      m_bl    <= '0;
      m_dp    <= '0;
      m_dash  <= 1'b0;
      sb.delete();
    end else begin
      sb.push_back(mk_exp());
      if (m_cnt == 9) begin
        m_cnt <= 0;
        m_idx <= (m_idx == 5) ? 0 : m_idx + 1;
        if (m_idx == 5) begin
          m_f    <= fields;
          m_bl   <= blink_mask;
          m_dp   <= dp_mask;
          m_dash <= dash;
        end
      end else begin
        m_cnt <= m_cnt + 1;
      end
      if (m_bcnt == 49) begin
        m_bcnt  <= 0;
        m_phase <= ~m_phase;
      end else begin
        m_bcnt <= m_bcnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && sb.size() > 0) begin
      e_pop = sb.pop_front();
      chk("sb_dig", 32'(dig), 32'(e_pop.dig));
      chk("sb_seg", 32'(seg), 32'(e_pop.seg));
      chk("sb_frame_tick", 32'(frame_tick), 32'(e_pop.ft));
    end
  end

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 200);
    chk("frame_wait", 32'(frame_tick), 32'd1);
  endtask

  task automatic first_show(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dig === 6'h3F && n < 30);
    chk({tag, "_dig"}, 32'(dig), 32'h3E);
    chk({tag, "_latency"}, n, 3);
    chk({tag, "_seg"}, 32'(seg), 32'h3F);
  endtask

  typedef struct packed {
    logic [20:0] f;
    logic [5:0]  dp;
    logic        dsh;
    logic [47:0] segs;  // idx5 .. idx0
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [5:0] ed;
    logic [7:0] es;
    int on_cnt, off_cnt, on01, off01, off_oth;

    vt[0] = '{f: {7'd12, 7'd34, 7'd56}, dp: 6'h00, dsh: 1'b0,
              segs: {8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D}};
    vt[1] = '{f: {7'd12, 7'd34, 7'd56}, dp: 6'h3F, dsh: 1'b1,
              segs: {8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40}};
    vt[2] = '{f: {7'd12, 7'd120, 7'd56}, dp: 6'h02, dsh: 1'b0,
              segs: {8'h06, 8'h5B, 8'h40, 8'h40, 8'hED, 8'h7D}};
    vt[3] = '{f: {7'd99, 7'd0, 7'd7}, dp: 6'h21, dsh: 1'b0,
              segs: {8'hEF, 8'h6F, 8'h3F, 8'h3F, 8'h3F, 8'h87}};
    vt[4] = '{f: {7'd100, 7'd127, 7'd89}, dp: 6'h00, dsh: 1'b0,
              segs: {8'h40, 8'h40, 8'h40, 8'h40, 8'h7F, 8'h6F}};
    vt[5] = '{f: {7'd45, 7'd67, 7'd8}, dp: 6'h00, dsh: 1'b0,
              segs: {8'h66, 8'h6D, 8'h7D, 8'h07, 8'h3F, 8'h7F}};

    // Power-on reset
    repeat (3) @(negedge clk);
    chk("reset_dig", 32'(dig), 32'h3F);
    chk("reset_seg", 32'(seg), 32'h00);
    chk("reset_frame_tick", 32'(frame_tick), 32'd0);
    #2 rst_n = 1'b1;
    first_show("por_first_show");

    // Table of frame-level vectors
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      fields     = vt[i].f;
      dp_mask    = vt[i].dp;
      dash       = vt[i].dsh;
      blink_mask = 3'b000;
      wait_frame();
      for (int k = 0; k < 6; k++) begin
        repeat ((k == 0) ? 6 : 10) @(negedge clk);
        ed = ~(6'b1 << k);
        es = 8'(vt[i].segs >> (8 * k));
        chk($sformatf("vec%0d_idx%0d_dig", i, k), 32'(dig), 32'(ed));
        chk($sformatf("vec%0d_idx%0d_seg", i, k), 32'(seg), 32'(es));
      end
    end

    // Digit duty: 8 lit cycles, 2 blank cycles per slot
    @(negedge clk);
    fields  = {7'd12, 7'd34, 7'd56};
    dp_mask = 6'h00;
    dash    = 1'b0;
    wait_frame();
    wait_frame();
    repeat (20) @(negedge clk);
    on_cnt = 0;
    off_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (dig === 6'b111011) on_cnt++;
      else if (dig === 6'h3F) off_cnt++;
    end
    chk("duty_show_cycles", on_cnt, 8);
    chk("duty_blank_cycles", off_cnt, 2);

    // Mid-frame change stays hidden until the next snapshot
    wait_frame();
    repeat (5) @(negedge clk);
    fields = {7'd12, 7'd34, 7'd7};
    repeat (11) @(negedge clk);
    chk("midframe_idx1_old", 32'(seg), 32'h6D);
    repeat (20) @(negedge clk);
    chk("midframe_idx3_old", 32'(seg), 32'h4F);
    wait_frame();
    repeat (6) @(negedge clk);
    chk("newframe_idx0", 32'(seg), 32'h07);
    repeat (10) @(negedge clk);
    chk("newframe_idx1", 32'(seg), 32'h3F);

    // Blink on field 0 only
    @(negedge clk);
    fields     = {7'd12, 7'd34, 7'd56};
    blink_mask = 3'b001;
    wait_frame();
    on01 = 0;
    off01 = 0;
    off_oth = 0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (dig === 6'h3E || dig === 6'h3D) begin
        if (seg === 8'h00) off01++;
        else on01++;
      end else if (dig !== 6'h3F && seg === 8'h00) begin
        off_oth++;
      end
    end
    chk("blink_field0_off_seen", 32'(off01 > 0), 32'd1);
    chk("blink_field0_on_seen", 32'(on01 > 0), 32'd1);
    chk("blink_other_fields_never_off", off_oth, 0);

    // Dash outranks blink
    @(negedge clk);
    dash    = 1'b1;
    dp_mask = 6'h3F;
    wait_frame();
    for (int j = 0; j < 120; j++) begin
      @(negedge clk);
      if (dig !== 6'h3F) chk("dash_over_blink", 32'(seg), 32'h40);
    end

    // Reset mid-slot at idx 3, cnt 5
    @(negedge clk);
    dash       = 1'b0;
    dp_mask    = 6'h00;
    blink_mask = 3'b000;
    wait_frame();
    wait_frame();
    repeat (35) @(negedge clk);
    chk("pre_reset_idx3", 32'(dig), 32'h37);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_dig", 32'(dig), 32'h3F);
    chk("async_reset_seg", 32'(seg), 32'h00);
    chk("async_reset_frame_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    first_show("rerun_first_show");

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
